fft_top_peaks: RTL and testbench

- Streaming top-N peak finder for FFT magnitude windows. Successor to the single-peak finder in the microphone path.
- Keeps a descending sorted list of the NPeaks largest magnitudes in a window of NSamples. Supports a programmable bin range [k_min, k_max], a threshold, and selectable bit-reversed or natural input order.
- After each window, drains the list over a valid/ready handshake to the pitch/beat classifier downstream of the FFT magnitude stage.

---
 rtl/fft_top_peaks.sv | 159 +++++++++++++++
 tb/tb_fft_top_peaks.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_top_peaks.sv
// Streaming top-N peak finder: keeps a descending sorted list of the NPeaks largest in-range,
// above-threshold magnitudes per window, then drains it rank by rank over valid/ready.
module fft_top_peaks #(
    parameter int NSamples    = 1024,
    parameter int W           = 33,
    parameter int NPeaks      = 4,
    parameter int BitReversed = 1,
    parameter int NBits       = $clog2(NSamples),
    parameter int RBits       = ($clog2(NPeaks) > 0 ? $clog2(NPeaks) : 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     mag,
    input  logic             mag_valid,
    output logic             mag_ready,
    input  logic [NBits-1:0] k_min,
    input  logic [NBits-1:0] k_max,
    input  logic [W-1:0]     threshold,
    output logic [W-1:0]     peak_out,
    output logic [NBits-1:0] peak_k_out,
    output logic [RBits-1:0] peak_rank,
    output logic             peak_out_valid,
    input  logic             peak_out_ready,
    output logic [RBits:0]   peak_count,
    output logic             window_done,
    output logic             overrun
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t           state, state_nx;
    logic [NBits-1:0] idx;
    logic [RBits:0]   r;
    logic [W-1:0]     lm [NPeaks];
    logic [NBits-1:0] lk [NPeaks];
    logic [NPeaks-1:0] lv;

    logic [W-1:0]     nm [NPeaks];
    logic [NBits-1:0] nk [NPeaks];
    logic [NPeaks-1:0] nv;
    logic [NPeaks-1:0] cond;
    logic [RBits:0]   nxt_cnt;
    logic [NBits-1:0] k;
    logic             accept, eligible, last;

    function automatic logic [NBits-1:0] bitrev(input logic [NBits-1:0] x);
        logic [NBits-1:0] y;
        for (int b = 0; b < NBits; b++) y[b] = x[NBits-1-b];
        return y;
    endfunction

    assign accept   = (state == COLLECT) && mag_valid;
    assign k        = (BitReversed != 0) ? bitrev(idx) : idx;
    assign eligible = (k >= k_min) && (k <= k_max) && (mag > threshold);
    assign last     = (idx == NBits'(NSamples - 1));

    // The list stays sorted with valid entries first, so cond is monotonic and the
    // insertion point is simply the first rank where it turns true.
    always_comb begin
        for (int j = 0; j < NPeaks; j++) begin
            cond[j] = !lv[j] || (lm[j] < mag);
            nm[j]   = lm[j];
            nk[j]   = lk[j];
            nv[j]   = lv[j];
        end
        if (accept && eligible) begin
            if (cond[0]) begin
                nm[0] = mag;
                nk[0] = k;
                nv[0] = 1'b1;
            end
            for (int j = 1; j < NPeaks; j++) begin
                if (cond[j]) begin
                    if (cond[j-1]) begin
                        nm[j] = lm[j-1];
                        nk[j] = lk[j-1];
                        nv[j] = lv[j-1];
                    end else begin
                        nm[j] = mag;
                        nk[j] = k;
                        nv[j] = 1'b1;
                    end
                end
            end
        end
        nxt_cnt = '0;
        for (int j = 0; j < NPeaks; j++) nxt_cnt = nxt_cnt + (RBits+1)'(nv[j]);
    end

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (accept && last) state_nx = DRAIN;
            DRAIN:   if (!peak_out_valid) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COLLECT;
            idx        <= '0;
            r          <= '0;
            peak_count <= '0;
            lv         <= '0;
            for (int j = 0; j < NPeaks; j++) begin
                lm[j] <= '0;
                lk[j] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == COLLECT) begin
                if (accept) begin
                    idx <= idx + 1'b1;
                    lv  <= nv;
                    for (int j = 0; j < NPeaks; j++) begin
                        lm[j] <= nm[j];
                        lk[j] <= nk[j];
                    end
                    if (last) begin
                        peak_count <= nxt_cnt;
                        r          <= '0;
                    end
                end
            end else if (peak_out_valid) begin
                if (peak_out_ready) r <= r + 1'b1;
            end else begin
                r          <= '0;
                peak_count <= '0;
                lv         <= '0;
                for (int j = 0; j < NPeaks; j++) begin
                    lm[j] <= '0;
                    lk[j] <= '0;
                end
            end
        end
    end

    assign mag_ready      = (state == COLLECT);
    assign peak_out_valid = (state == DRAIN) && (r < peak_count);
    assign window_done    = (state == DRAIN) && !(r < peak_count);
    assign overrun        = mag_valid && !mag_ready;

    always_comb begin
        peak_out   = '0;
        peak_k_out = '0;
        peak_rank  = '0;
        if (peak_out_valid) begin
            peak_rank = r[RBits-1:0];
            for (int j = 0; j < NPeaks; j++) begin
                if (r == (RBits+1)'(j)) begin
                    peak_out   = lm[j];
                    peak_k_out = lk[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_top_peaks.sv
// Directed bench for fft_top_peaks: natural-order and bit-reversed instances, NSamples=16, NPeaks=4, W=16.
module tb_fft_top_peaks;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mag;
    logic        mag_valid, mag_valid_br;
    logic        mag_ready, mag_ready_br;
    logic [3:0]  k_min, k_max;
    logic [15:0] threshold;
    logic [15:0] peak_out, peak_out_br;
    logic [3:0]  peak_k_out, peak_k_out_br;
    logic [1:0]  peak_rank, peak_rank_br;
    logic        peak_out_valid, peak_out_valid_br;
    logic        peak_out_ready, peak_out_ready_br;
    logic [2:0]  peak_count, peak_count_br;
    logic        window_done, window_done_br;
    logic        overrun, overrun_br;

    int checks = 0;
    int passed = 0;

    logic [15:0] w1 [16];
    logic [15:0] w2 [16];
    logic [15:0] w3 [16];
    logic [15:0] w5 [16];

    always #5 clk = ~clk;

    fft_top_peaks #(.NSamples(16), .W(16), .NPeaks(4), .BitReversed(0)) dut (
        .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid), .mag_ready(mag_ready),
        .k_min(k_min), .k_max(k_max), .threshold(threshold),
        .peak_out(peak_out), .peak_k_out(peak_k_out), .peak_rank(peak_rank),
        .peak_out_valid(peak_out_valid), .peak_out_ready(peak_out_ready),
        .peak_count(peak_count), .window_done(window_done), .overrun(overrun)
    );

    fft_top_peaks #(.NSamples(16), .W(16), .NPeaks(4), .BitReversed(1)) dut_br (
        .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid_br), .mag_ready(mag_ready_br),
        .k_min(k_min), .k_max(k_max), .threshold(threshold),
        .peak_out(peak_out_br), .peak_k_out(peak_k_out_br), .peak_rank(peak_rank_br),
        .peak_out_valid(peak_out_valid_br), .peak_out_ready(peak_out_ready_br),
        .peak_count(peak_count_br), .window_done(window_done_br), .overrun(overrun_br)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_window(input logic [15:0] m [16], input int n);
        for (int i = 0; i < n; i++) begin
            mag       = m[i];
            mag_valid = 1'b1;
            tick();
        end
        mag_valid = 1'b0;
        mag       = '0;
    endtask

    // Drains n entries with ready held high, then checks the window_done cycle and the return to COLLECT.
    task automatic drain(input string nm, input int n, input logic [15:0] em [4], input logic [3:0] ek [4]);
        peak_out_ready = 1'b1;
        checks++; if (peak_count !== 3'(n)) $display("FAIL %s count: got %0d want %0d", nm, peak_count, n); else passed++;
        for (int e = 0; e < n; e++) begin
            checks++;
            if (peak_out_valid !== 1'b1 || peak_out !== em[e] || peak_k_out !== ek[e] ||
                peak_rank !== 2'(e) || window_done !== 1'b0 || mag_ready !== 1'b0)
                $display("FAIL %s entry%0d: got v=%b mag=%0d k=%0d rank=%0d wd=%b rdy=%b want mag=%0d k=%0d",
                         nm, e, peak_out_valid, peak_out, peak_k_out, peak_rank, window_done, mag_ready, em[e], ek[e]);
            else passed++;
            tick();
        end
        checks++;
        if (peak_out_valid !== 1'b0 || window_done !== 1'b1)
            $display("FAIL %s done: got v=%b wd=%b want v=0 wd=1", nm, peak_out_valid, window_done);
        else passed++;
        tick();
        checks++;
        if (window_done !== 1'b0 || mag_ready !== 1'b1 || peak_count !== 3'd0)
            $display("FAIL %s after: got wd=%b rdy=%b cnt=%0d want wd=0 rdy=1 cnt=0", nm, window_done, mag_ready, peak_count);
        else passed++;
        peak_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (mag_ready !== 1'b1 || peak_out_valid !== 1'b0 || peak_count !== 3'd0 || window_done !== 1'b0 ||
            overrun !== 1'b0 || peak_out !== 16'd0 || peak_k_out !== 4'd0 || peak_rank !== 2'd0)
            $display("FAIL reset: got rdy=%b v=%b cnt=%0d wd=%b ov=%b out=%0d", mag_ready, peak_out_valid,
                     peak_count, window_done, overrun, peak_out);
        else passed++;
        reset = 1'b0;
        tick();
        checks++; if (mag_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", mag_ready); else passed++;
    endtask

    task automatic test_basic();
        logic [15:0] em [4] = '{16'd70, 16'd50, 16'd50, 16'd30};
        logic [3:0]  ek [4] = '{4'd4, 4'd1, 4'd3, 4'd2};
        k_min = 4'd0; k_max = 4'd15; threshold = 16'd0;
        send_window(w1, 16);
        drain("basic", 4, em, ek);
    endtask

    task automatic test_range_threshold();
        logic [15:0] em [4] = '{16'd80, 16'd60, 16'd40, 16'd0};
        logic [3:0]  ek [4] = '{4'd2, 4'd5, 4'd4, 4'd0};
        k_min = 4'd2; k_max = 4'd5; threshold = 16'd25;
        send_window(w2, 16);
        drain("range", 3, em, ek);
        k_min = 4'd0; k_max = 4'd15; threshold = 16'd0;
    endtask

    task automatic test_bitrev();
        mag_valid_br = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mag          = w3[i];
            mag_valid_br = 1'b1;
            tick();
        end
        mag_valid_br      = 1'b0;
        peak_out_ready_br = 1'b1;
        checks++;
        if (peak_out_valid_br !== 1'b1 || peak_out_br !== 16'd500 || peak_k_out_br !== 4'd8 || peak_count_br !== 3'd1)
            $display("FAIL bitrev entry: got v=%b mag=%0d k=%0d cnt=%0d want 1/500/8/1", peak_out_valid_br,
                     peak_out_br, peak_k_out_br, peak_count_br);
        else passed++;
        tick();
        checks++;
        if (peak_out_valid_br !== 1'b0 || window_done_br !== 1'b1)
            $display("FAIL bitrev done: got v=%b wd=%b want 0/1", peak_out_valid_br, window_done_br);
        else passed++;
        tick();
        peak_out_ready_br = 1'b0;
        checks++; if (mag_ready_br !== 1'b1) $display("FAIL bitrev ready: got %b want 1", mag_ready_br); else passed++;
    endtask

    task automatic test_stall_overrun();
        logic [15:0] em1 [4] = '{16'd70, 16'd50, 16'd50, 16'd30};
        logic [3:0]  ek1 [4] = '{4'd4, 4'd1, 4'd3, 4'd2};
        logic [15:0] em2 [4] = '{16'd100, 16'd99, 16'd90, 16'd80};
        logic [3:0]  ek2 [4] = '{4'd0, 4'd6, 4'd1, 4'd2};
        send_window(w1, 16);
        peak_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                mag = 16'd999; mag_valid = 1'b1;
                #1;
                checks++;
                if (overrun !== 1'b1 || mag_ready !== 1'b0)
                    $display("FAIL overrun pulse: got ov=%b rdy=%b want 1/0", overrun, mag_ready);
                else passed++;
            end
            checks++;
            if (peak_out_valid !== 1'b1 || peak_out !== 16'd70 || peak_k_out !== 4'd4 || peak_rank !== 2'd0)
                $display("FAIL stall%0d: got v=%b mag=%0d k=%0d rank=%0d want 1/70/4/0", c, peak_out_valid,
                         peak_out, peak_k_out, peak_rank);
            else passed++;
            tick();
            if (c == 2) begin
                mag_valid = 1'b0; mag = '0;
                #1;
                checks++; if (overrun !== 1'b0) $display("FAIL overrun single: got %b want 0", overrun); else passed++;
            end
        end
        drain("stalled", 4, em1, ek1);
        send_window(w2, 16);
        drain("next_window", 4, em2, ek2);
    endtask

    task automatic test_empty();
        threshold = 16'd100;
        send_window(w5, 16);
        checks++;
        if (peak_out_valid !== 1'b0 || window_done !== 1'b1 || peak_count !== 3'd0 || mag_ready !== 1'b0)
            $display("FAIL empty first: got v=%b wd=%b cnt=%0d rdy=%b want 0/1/0/0", peak_out_valid, window_done,
                     peak_count, mag_ready);
        else passed++;
        tick();
        checks++;
        if (window_done !== 1'b0 || mag_ready !== 1'b1)
            $display("FAIL empty after: got wd=%b rdy=%b want 0/1", window_done, mag_ready);
        else passed++;
        threshold = 16'd0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] em1 [4] = '{16'd70, 16'd50, 16'd50, 16'd30};
        logic [3:0]  ek1 [4] = '{4'd4, 4'd1, 4'd3, 4'd2};
        logic [15:0] em2 [4] = '{16'd100, 16'd99, 16'd90, 16'd80};
        logic [3:0]  ek2 [4] = '{4'd0, 4'd6, 4'd1, 4'd2};
        send_window(w1, 9);
        reset = 1'b1;
        tick();
        checks++;
        if (mag_ready !== 1'b1 || peak_out_valid !== 1'b0 || peak_count !== 3'd0 || window_done !== 1'b0 || peak_out !== 16'd0)
            $display("FAIL reset_collect: got rdy=%b v=%b cnt=%0d wd=%b out=%0d", mag_ready, peak_out_valid,
                     peak_count, window_done, peak_out);
        else passed++;
        reset = 1'b0;
        send_window(w1, 16);
        drain("after_reset_collect", 4, em1, ek1);
        send_window(w1, 16);
        peak_out_ready = 1'b1;
        tick();
        peak_out_ready = 1'b0;
        checks++; if (peak_rank !== 2'd1) $display("FAIL pre_reset_rank: got %0d want 1", peak_rank); else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if (mag_ready !== 1'b1 || peak_out_valid !== 1'b0 || peak_count !== 3'd0 || window_done !== 1'b0 ||
            peak_out !== 16'd0 || peak_rank !== 2'd0)
            $display("FAIL reset_drain: got rdy=%b v=%b cnt=%0d wd=%b out=%0d rank=%0d", mag_ready, peak_out_valid,
                     peak_count, window_done, peak_out, peak_rank);
        else passed++;
        reset = 1'b0;
        send_window(w2, 16);
        drain("after_reset_drain", 4, em2, ek2);
    endtask

    initial begin
        w1 = '{16'd10, 16'd50, 16'd30, 16'd50, 16'd70, 16'd20, 16'd5, 16'd0,
               16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        w2 = '{16'd100, 16'd90, 16'd80, 16'd10, 16'd40, 16'd60, 16'd99, 16'd1,
               16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        w3 = '{16'd0, 16'd500, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
               16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        w5 = '{16'd100, 16'd50, 16'd99, 16'd0, 16'd100, 16'd7, 16'd1, 16'd100,
               16'd3, 16'd100, 16'd60, 16'd100, 16'd2, 16'd100, 16'd80, 16'd100};
        reset = 1'b1; mag = '0; mag_valid = 1'b0; mag_valid_br = 1'b0;
        peak_out_ready = 1'b0; peak_out_ready_br = 1'b0;
        k_min = 4'd0; k_max = 4'd15; threshold = 16'd0;
        test_reset();
        test_basic();
        test_range_threshold();
        test_bitrev();
        test_stall_overrun();
        test_empty();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
